// File: rtl/csi_packet_framer.sv
// CSI-2 receive packet framer: assembles the packet header, strips CRC and emits 32-bit payload words.
// Optional build macro PH_ECC_CHECK_EN enables packet header ECC checking.
module csi_packet_framer #(
  parameter int unsigned LANES = 2,
  localparam int unsigned IN_W = 8 * LANES
) (
  input  logic            rxbyteclkhs,
  input  logic            reset,
  input  logic [IN_W-1:0] word_in,
  input  logic            in_valid,
  output logic [31:0]     ph_out,
  output logic            ph_valid,
  output logic [5:0]      data_type,
  output logic [1:0]      virtual_channel,
  output logic [15:0]     word_count,
  output logic            short_pkt,
  output logic [31:0]     payload_out,
  output logic            payload_valid,
  output logic [3:0]      payload_be,
  output logic            payload_last,
  output logic            pkt_done,
  output logic            pkt_error,
  output logic            ecc_error
);

  localparam int unsigned REM_W = 17;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [31:0]      hdr, hdr_n;
  logic [1:0]       hcnt, hcnt_n;
  logic [REM_W-1:0] rem, rem_n;
  logic [31:0]      acc, acc_n;
  logic [2:0]       acnt, acnt_n;

  logic [31:0] ph_out_n, payload_out_n, hdr_w;
  logic [5:0]  data_type_n;
  logic [1:0]  vc_n;
  logic [15:0] word_count_n;
  logic [3:0]  payload_be_n;
  logic [7:0]  byte_c;
  logic        short_pkt_n, ph_valid_n, payload_valid_n, payload_last_n, pkt_done_n, pkt_error_n;

`ifdef PH_ECC_CHECK_EN
  logic ecc_error_n;

  // Hamming parity over PH[23:0]; one mask per ECC bit, P5 first
  function automatic logic [5:0] ph_ecc(input logic [23:0] d);
    return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction
`endif

  // Walk every byte of the word in wire order; a word may cross several states
  always_comb begin
    state_n         = state;
    hdr_n           = hdr;
    hcnt_n          = hcnt;
    rem_n           = rem;
    acc_n           = acc;
    acnt_n          = acnt;
    ph_out_n        = ph_out;
    data_type_n     = data_type;
    vc_n            = virtual_channel;
    word_count_n    = word_count;
    short_pkt_n     = short_pkt;
    payload_out_n   = payload_out;
    payload_be_n    = payload_be;
    ph_valid_n      = 1'b0;
    payload_valid_n = 1'b0;
    payload_last_n  = 1'b0;
    pkt_done_n      = 1'b0;
    pkt_error_n     = 1'b0;
`ifdef PH_ECC_CHECK_EN
    ecc_error_n     = 1'b0;
`endif
    byte_c          = '0;
    hdr_w           = '0;

    if (!in_valid) begin
      pkt_error_n = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_TRAILER);
      state_n     = S_IDLE;
      hcnt_n      = '0;
      rem_n       = '0;
      acc_n       = '0;
      acnt_n      = '0;
    end else begin
      if (state == S_IDLE) begin
        state_n = S_HEADER;
        hcnt_n  = '0;
      end
      for (int unsigned i = 0; i < LANES; i++) begin
        byte_c = word_in[8*i +: 8];
        case (state_n)
          S_HEADER: begin
            if (hcnt_n != 2'd3) begin
              hdr_n[{hcnt_n, 3'b000} +: 8] = byte_c;
              hcnt_n = hcnt_n + 2'd1;
            end else begin
              hdr_w        = {byte_c, hdr_n[23:0]};
              hcnt_n       = '0;
              ph_valid_n   = 1'b1;
              ph_out_n     = hdr_w;
              data_type_n  = hdr_w[5:0];
              vc_n         = hdr_w[7:6];
              word_count_n = hdr_w[23:8];
              short_pkt_n  = (hdr_w[5:0] <= 6'h0F);
`ifdef PH_ECC_CHECK_EN
              if ((hdr_w[31:30] != 2'b00) || (hdr_w[29:24] != ph_ecc(hdr_w[23:0]))) begin
                ecc_error_n = 1'b1;
                state_n     = S_DRAIN;
              end else
`endif
              if ((hdr_w[5:0] <= 6'h0F) || (hdr_w[23:8] == 16'd0)) begin
                pkt_done_n = 1'b1;
                state_n    = S_DRAIN;
              end else begin
                rem_n   = {1'b0, hdr_w[23:8]} + 17'd2;
                acc_n   = '0;
                acnt_n  = '0;
                state_n = S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            acc_n[{acnt_n[1:0], 3'b000} +: 8] = byte_c;
            acnt_n = acnt_n + 3'd1;
            rem_n  = rem_n - 17'd1;
            if ((acnt_n == 3'd4) || (rem_n == 17'd2)) begin
              payload_valid_n = 1'b1;
              payload_out_n   = acc_n;
              payload_be_n    = 4'((5'd1 << acnt_n) - 5'd1);
              payload_last_n  = (rem_n == 17'd2);
              acc_n           = '0;
              acnt_n          = '0;
            end
            if (rem_n == 17'd2) state_n = S_TRAILER;
          end
          S_TRAILER: begin
            rem_n = rem_n - 17'd1;
            if (rem_n == 17'd0) begin
              pkt_done_n = 1'b1;
              state_n    = S_DRAIN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state           <= S_IDLE;
      hdr             <= '0;
      hcnt            <= '0;
      rem             <= '0;
      acc             <= '0;
      acnt            <= '0;
      ph_out          <= '0;
      ph_valid        <= 1'b0;
      data_type       <= '0;
      virtual_channel <= '0;
      word_count      <= '0;
      short_pkt       <= 1'b0;
      payload_out     <= '0;
      payload_valid   <= 1'b0;
      payload_be      <= '0;
      payload_last    <= 1'b0;
      pkt_done        <= 1'b0;
      pkt_error       <= 1'b0;
    end else begin
      state           <= state_n;
      hdr             <= hdr_n;
      hcnt            <= hcnt_n;
      rem             <= rem_n;
      acc             <= acc_n;
      acnt            <= acnt_n;
      ph_out          <= ph_out_n;
      ph_valid        <= ph_valid_n;
      data_type       <= data_type_n;
      virtual_channel <= vc_n;
      word_count      <= word_count_n;
      short_pkt       <= short_pkt_n;
      payload_out     <= payload_out_n;
      payload_valid   <= payload_valid_n;
      payload_be      <= payload_be_n;
      payload_last    <= payload_last_n;
      pkt_done        <= pkt_done_n;
      pkt_error       <= pkt_error_n;
    end
  end

`ifdef PH_ECC_CHECK_EN
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) ecc_error <= 1'b0;
    else       ecc_error <= ecc_error_n;
  end
`else
  assign ecc_error = 1'b0;
`endif

endmodule

// File: tb/tb_csi_packet_framer.sv
// Bench for csi_packet_framer: one instance each for LANES=1, 2, 4 driven from a shared vector table.
module tb_csi_packet_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] w4;
  logic        iv         [3];
  logic [31:0] ph_out_a   [3];
  logic        ph_valid_a [3];
  logic [5:0]  dt_a       [3];
  logic [1:0]  vc_a       [3];
  logic [15:0] wc_a       [3];
  logic        sp_a       [3];
  logic [31:0] pd_a       [3];
  logic        pv_a       [3];
  logic [3:0]  be_a       [3];
  logic        pl_a       [3];
  logic        done_a     [3];
  logic        err_a      [3];
  logic        ecc_a      [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = 1 << g;
    csi_packet_framer #(.LANES(L)) u_dut (
      .rxbyteclkhs    (clk),
      .reset          (reset),
      .word_in        (w4[8*L-1:0]),
      .in_valid       (iv[g]),
      .ph_out         (ph_out_a[g]),
      .ph_valid       (ph_valid_a[g]),
      .data_type      (dt_a[g]),
      .virtual_channel(vc_a[g]),
      .word_count     (wc_a[g]),
      .short_pkt      (sp_a[g]),
      .payload_out    (pd_a[g]),
      .payload_valid  (pv_a[g]),
      .payload_be     (be_a[g]),
      .payload_last   (pl_a[g]),
      .pkt_done       (done_a[g]),
      .pkt_error      (err_a[g]),
      .ecc_error      (ecc_a[g])
    );
  end

  typedef struct {
    int          k;
    logic        rst;
    logic        iv;
    logic [31:0] w;
    logic        phv;
    logic [7:0]  di;
    logic [15:0] wc;
    logic        sp;
    logic        ecc;
    logic        pv;
    logic [31:0] pd;
    logic [3:0]  be;
    logic        pl;
    logic        done;
    logic        err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  // Packet header as it appears on the wire, ECC from the per-bit column codes
  function automatic logic [31:0] ph(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ECC_COL[i];
    return {2'b00, e, wc, di};
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int j = 0; j < 4; j++) if (be[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %h want %h", nm, n, act, exp);
    end
  endtask

  task automatic add(input int k, input logic rst, input logic v_iv, input logic [31:0] w,
                     input logic phv, input logic [7:0] di, input logic [15:0] wc, input logic ecc,
                     input logic pv, input logic [31:0] pd, input logic [3:0] be, input logic pl,
                     input logic done, input logic err);
    vec_t v;
    v.k = k; v.rst = rst; v.iv = v_iv; v.w = w; v.phv = phv; v.di = di; v.wc = wc;
    v.sp = (di[5:0] <= 6'h0F); v.ecc = ecc; v.pv = pv; v.pd = pd; v.be = be; v.pl = pl;
    v.done = done; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic nop(input int k, input logic v_iv, input logic [31:0] w);
    add(k, 1'b0, v_iv, w, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic hd(input int k, input logic [31:0] w, input logic [7:0] di, input logic [15:0] wc,
                    input logic done, input logic ecc);
    add(k, 1'b0, 1'b1, w, 1'b1, di, wc, ecc, 1'b0, 32'h0, 4'h0, 1'b0, done, 1'b0);
  endtask
  task automatic py(input int k, input logic [31:0] w, input logic [31:0] pd, input logic [3:0] be,
                    input logic pl, input logic done);
    add(k, 1'b0, 1'b1, w, 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, pd, be, pl, done, 1'b0);
  endtask
  task automatic dn(input int k, input logic [31:0] w);
    add(k, 1'b0, 1'b1, w, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic er(input int k);
    add(k, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic rs(input int k, input logic [31:0] w);
    add(k, 1'b1, 1'b1, w, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_vec(input int n, input vec_t v);
    int k;
    k = v.k;
    chk("ph_valid",      n, 32'(ph_valid_a[k]), 32'(v.phv));
    chk("payload_valid", n, 32'(pv_a[k]),       32'(v.pv));
    chk("payload_last",  n, 32'(pl_a[k]),       32'(v.pl));
    chk("pkt_done",      n, 32'(done_a[k]),     32'(v.done));
    chk("pkt_error",     n, 32'(err_a[k]),      32'(v.err));
    chk("ecc_error",     n, 32'(ecc_a[k]),      32'(v.ecc));
    if (v.phv) begin
      chk("data_type",       n, 32'(dt_a[k]),           32'(v.di[5:0]));
      chk("virtual_channel", n, 32'(vc_a[k]),           32'(v.di[7:6]));
      chk("word_count",      n, 32'(wc_a[k]),           32'(v.wc));
      chk("short_pkt",       n, 32'(sp_a[k]),           32'(v.sp));
      chk("ph_out_lo",       n, 32'(ph_out_a[k][23:0]), 32'({v.wc, v.di}));
    end
    if (v.pv) begin
      chk("payload_be",  n, 32'(be_a[k]), 32'(v.be));
      chk("payload_out", n, pd_a[k] & bmask(v.be), v.pd & bmask(v.be));
    end
  endtask

  logic [31:0] h, w;
  int          good;
  logic        last_pv, last_pl, last_done;
  logic [3:0]  last_be;
  logic [31:0] last_pd;

  initial begin
    reset = 1'b1;
    w4    = '0;
    for (int g = 0; g < 3; g++) iv[g] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_ph_out",  g, ph_out_a[g], 32'h0);
      chk("rst_payload", g, pd_a[g], 32'h0);
      chk("rst_fields",  g, 32'({dt_a[g], vc_a[g], wc_a[g]}), 32'h0);
      chk("rst_flags",   g, 32'({ph_valid_a[g], pv_a[g], pl_a[g], done_a[g], err_a[g],
                                 ecc_a[g], sp_a[g], be_a[g]}), 32'h0);
    end

    // LANES=2 long packet, WC=6
    h = ph(8'h2A, 16'd6);
    nop(1, 1'b1, 32'(h[15:0]));
    hd(1, 32'(h[31:16]), 8'h2A, 16'd6, 1'b0, 1'b0);
    nop(1, 1'b1, 32'h1211);
    py(1, 32'h1413, 32'h14131211, 4'hF, 1'b0, 1'b0);
    py(1, 32'h1615, 32'h00001615, 4'h3, 1'b1, 1'b0);
    dn(1, 32'hC2C1);
    nop(1, 1'b1, 32'hFFFF);
    nop(1, 1'b0, 32'h0);
    // LANES=4 short packet (frame start)
    hd(2, ph(8'h00, 16'd1), 8'h00, 16'd1, 1'b1, 1'b0);
    nop(2, 1'b1, 32'hDEADBEEF);
    nop(2, 1'b0, 32'h0);
    // LANES=4 WC=8, CRC in the following word
    hd(2, ph(8'h6B, 16'd8), 8'h6B, 16'd8, 1'b0, 1'b0);
    py(2, 32'h44332211, 32'h44332211, 4'hF, 1'b0, 1'b0);
    py(2, 32'h88776655, 32'h88776655, 4'hF, 1'b1, 1'b0);
    dn(2, 32'hEEDDC2C1);
    nop(2, 1'b0, 32'h0);
    // LANES=4 WC=6, CRC shares the last payload word
    hd(2, ph(8'hAA, 16'd6), 8'hAA, 16'd6, 1'b0, 1'b0);
    py(2, 32'h44332211, 32'h44332211, 4'hF, 1'b0, 1'b0);
    py(2, 32'hC2C16655, 32'h00006655, 4'h3, 1'b1, 1'b1);
    nop(2, 1'b0, 32'h0);
    // LANES=4 long packet with WC=0
    hd(2, ph(8'h2A, 16'd0), 8'h2A, 16'd0, 1'b1, 1'b0);
    nop(2, 1'b0, 32'h0);
    // LANES=1 WC=5 truncated after 3 payload bytes, then a WC=1 packet
    h = ph(8'h2A, 16'd5);
    nop(0, 1'b1, 32'(h[7:0]));
    nop(0, 1'b1, 32'(h[15:8]));
    nop(0, 1'b1, 32'(h[23:16]));
    hd(0, 32'(h[31:24]), 8'h2A, 16'd5, 1'b0, 1'b0);
    nop(0, 1'b1, 32'h11);
    nop(0, 1'b1, 32'h12);
    nop(0, 1'b1, 32'h13);
    er(0);
    nop(0, 1'b0, 32'h0);
    h = ph(8'h2C, 16'd1);
    nop(0, 1'b1, 32'(h[7:0]));
    nop(0, 1'b1, 32'(h[15:8]));
    nop(0, 1'b1, 32'(h[23:16]));
    hd(0, 32'(h[31:24]), 8'h2C, 16'd1, 1'b0, 1'b0);
    py(0, 32'hA5, 32'h000000A5, 4'h1, 1'b1, 1'b0);
    nop(0, 1'b1, 32'hC1);
    dn(0, 32'hC2);
    nop(0, 1'b0, 32'h0);
    // LANES=2 reset mid-payload, then a fresh packet
    h = ph(8'h2A, 16'd6);
    nop(1, 1'b1, 32'(h[15:0]));
    hd(1, 32'(h[31:16]), 8'h2A, 16'd6, 1'b0, 1'b0);
    nop(1, 1'b1, 32'h1211);
    rs(1, 32'h1413);
    nop(1, 1'b0, 32'h0);
    h = ph(8'h1E, 16'd4);
    nop(1, 1'b1, 32'(h[15:0]));
    hd(1, 32'(h[31:16]), 8'h1E, 16'd4, 1'b0, 1'b0);
    nop(1, 1'b1, 32'h0201);
    py(1, 32'h0403, 32'h04030201, 4'hF, 1'b1, 1'b0);
    dn(1, 32'hC2C1);
    nop(1, 1'b0, 32'h0);
`ifdef PH_ECC_CHECK_EN
    // Corrupted ECC: header flagged, packet dropped; then the same packet with good ECC
    hd(2, ph(8'h2A, 16'd4) ^ 32'h01000000, 8'h2A, 16'd4, 1'b0, 1'b1);
    nop(2, 1'b1, 32'h44332211);
    nop(2, 1'b1, 32'h0000C2C1);
    nop(2, 1'b0, 32'h0);
    hd(2, ph(8'h2A, 16'd4), 8'h2A, 16'd4, 1'b0, 1'b0);
    py(2, 32'h44332211, 32'h44332211, 4'hF, 1'b1, 1'b0);
    dn(2, 32'h0000C2C1);
    nop(2, 1'b0, 32'h0);
`endif

    for (int n = 0; n < tbl.size(); n++) begin
      reset = tbl[n].rst;
      for (int g = 0; g < 3; g++) iv[g] = 1'b0;
      iv[tbl[n].k] = tbl[n].iv;
      w4 = tbl[n].w;
      @(posedge clk);
      #1;
      check_vec(n, tbl[n]);
    end

    // LANES=4 maximum word count: 65535 payload bytes, counter must not overflow
    reset = 1'b0;
    h     = ph(8'h2A, 16'hFFFF);
    iv[2] = 1'b1;
    w4    = h;
    @(posedge clk);
    #1;
    chk("ffff_ph_valid",   0, 32'(ph_valid_a[2]), 32'h1);
    chk("ffff_word_count", 0, 32'(wc_a[2]), 32'hFFFF);
    good = 0;
    last_pv = 1'b0; last_pl = 1'b0; last_done = 1'b0; last_be = '0; last_pd = '0;
    for (int i = 0; i < 16384; i++) begin
      w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      if (i == 16383) w[31:24] = 8'hC1;
      w4 = w;
      @(posedge clk);
      #1;
      if (i < 16383) begin
        if (pv_a[2] && (be_a[2] == 4'hF) && !pl_a[2] && (pd_a[2] == w) && !done_a[2]) good++;
      end else begin
        last_pv = pv_a[2]; last_pl = pl_a[2]; last_be = be_a[2];
        last_pd = pd_a[2]; last_done = done_a[2];
      end
    end
    chk("ffff_full_words", 0, 32'(good), 32'd16383);
    chk("ffff_last_valid", 0, 32'(last_pv), 32'h1);
    chk("ffff_last_flag",  0, 32'(last_pl), 32'h1);
    chk("ffff_last_be",    0, 32'(last_be), 32'h7);
    chk("ffff_last_data",  0, last_pd & 32'h00FFFFFF, 32'h00FEFDFC);
    chk("ffff_early_done", 0, 32'(last_done), 32'h0);
    w4 = 32'h555555C2;
    @(posedge clk);
    #1;
    chk("ffff_done",       0, 32'(done_a[2]), 32'h1);
    chk("ffff_no_payload", 0, 32'(pv_a[2]), 32'h0);
    iv[2] = 1'b0;
    @(posedge clk);
    #1;
    chk("ffff_no_error",   0, 32'(err_a[2]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
